l1_round_robin_arbiter: RTL and testbench
=========================================

L1_ROUND_ROBIN_ARBITER -- requirements
Module: l1_round_robin_arbiter

Interface
REQ-001 The block SHALL have parameter L1_CONNECTIONS, default 4, the number of requestors indexed by l1_id_t (0=DCACHE, 1=ICACHE, 2=DMMU, 3=IMMU).
REQ-002 The block SHALL have parameter MAX_INFLIGHT, default 4, the depth of the read-response ID FIFO (power of 2).
REQ-003 Clock and reset SHALL be: clk in 1 (sole clock); rst in 1 (asynchronous, active-high).
REQ-004 req_valid in L1_CONNECTIONS, per-requestor request valid.
REQ-005 req_addr in L1_CONNECTIONS x 32, per-requestor word address.
REQ-006 req_rnw in L1_CONNECTIONS, 1 = read, 0 = write.
REQ-007 req_wdata in L1_CONNECTIONS x 32, write data.
REQ-008 req_ready out L1_CONNECTIONS, one-hot grant; a request transfers when valid and ready are both high.
REQ-009 l2_valid out 1, l2_addr out 32, l2_rnw out 1, l2_wdata out 32, l2_id out 2 carry the registered request to L2.
REQ-010 l2_ready in 1, L2 accepts l2_* when l2_valid and l2_ready are both high.
REQ-011 rsp_valid in 1, rsp_data in 32, in-order read response from L2.
REQ-012 port_rsp_valid out L1_CONNECTIONS, port_rsp_data out 32 carry the response routed to the originating requestor.

Function
REQ-013 Output register: at most one request held; grant permitted only when l2_valid=0 or (l2_valid and l2_ready) in the same cycle.
REQ-014 Grant latency: a granted request SHALL appear on l2_* on the next clock edge.
REQ-015 Round-robin: search starts at last_grant+1 mod L1_CONNECTIONS; the first valid requestor is granted; last_grant updates only on a transfer.
REQ-016 At most one req_ready bit SHALL be high per cycle; req_ready is combinational from req_valid, the pointer and the stall conditions.
REQ-017 A granted read SHALL push its ID into the ID FIFO on the grant cycle; writes SHALL NOT push.
REQ-018 ID FIFO full: read requests SHALL NOT be granted; write requests remain eligible, skipping ineligible reads in the round-robin search.
REQ-019 rsp_valid SHALL pop the FIFO head; port_rsp_valid[head]=1 in the same cycle (combinational); port_rsp_data = rsp_data.
REQ-020 Simultaneous push and pop when full SHALL NOT be allowed to admit the read (full evaluated before pop); a simultaneous push and pop when not full SHALL leave the count unchanged.
REQ-021 rsp_valid with an empty FIFO is a protocol error: no port_rsp_valid asserted, FIFO state unchanged, simulation assertion fires.
REQ-022 FIFO pointers SHALL wrap modulo MAX_INFLIGHT; count width is clog2(MAX_INFLIGHT)+1.
REQ-023 l2_* SHALL stay stable while l2_valid=1 and l2_ready=0.

Reset
REQ-024 On rst: l2_valid=0, l2_addr/l2_wdata/l2_id=0, l2_rnw=0, last_grant=L1_CONNECTIONS-1 (first search starts at 0), FIFO empty, req_ready=0 while rst high.
REQ-025 Reset mid-transaction SHALL discard the held request and all outstanding IDs; responses arriving after reset fall under REQ-021.

Configuration
REQ-026 Macro L1_ARB_FIXED_PRIORITY_EN: when defined, the search always starts at ID 0 (lowest ID wins) and last_grant is not implemented; when undefined, round-robin per REQ-015.

Verification
REQ-027 All four valid reads, l2_ready=1 always -> grants in order 0,1,2,3,0 on consecutive cycles; l2_id matches one cycle later.
REQ-028 Four reads granted with no responses, a fifth read from ID1 plus a write from ID2 -> ID1 stalled, ID2 write granted; after one rsp_valid, ID1 granted the next cycle.
REQ-029 l2_ready=0 for 3 cycles with l2_valid=1 (addr 0x80000040) -> l2_* stable, req_ready all 0, transfer on cycle 4.
REQ-030 Reads from IDs 3,0,2, then responses 0xA,0xB,0xC -> port_rsp_valid[3]=0xA, [0]=0xB, [2]=0xC in order.
REQ-031 rst asserted while l2_valid=1 and 2 IDs outstanding -> l2_valid=0 immediately (asynchronous), FIFO empty; the next grant goes to ID 0 when all are requesting.
REQ-032 With L1_ARB_FIXED_PRIORITY_EN defined, IDs 0 and 3 both continuously valid -> ID 0 is granted every cycle.

Source files
------------

// File: rtl/l1_round_robin_arbiter.sv
// l1_round_robin_arbiter
// Arbitrates L1 requestors (0=DCACHE, 1=ICACHE, 2=DMMU, 3=IMMU) onto one
// registered L2 request port. Read IDs are remembered in an in-order FIFO so
// that the L2 read responses can be routed back to the requestor that issued them.
//
// Ports
//   clk, rst           sole clock; asynchronous active-high reset
//   req_valid/addr/rnw/wdata   per-requestor request (addr/wdata 32b each)
//   req_ready          one-hot grant (combinational)
//   l2_valid/addr/rnw/wdata/id registered request to L2
//   l2_ready           L2 accepts l2_* when l2_valid && l2_ready
//   rsp_valid/rsp_data in-order read response from L2
//   port_rsp_valid     response routed to the originating requestor (combinational)
//   port_rsp_data      response data (rsp_data passed through)
//
// Configuration macro: L1_ARB_FIXED_PRIORITY_EN
//   defined   -> fixed priority, lowest ID wins, no last-grant pointer
//   undefined -> round-robin starting after the last granted requestor
//
// l2_id is 2 bits wide, so L1_CONNECTIONS must be between 2 and 4.
// MAX_INFLIGHT must be a power of 2.

module l1_round_robin_arbiter #(
  parameter int unsigned L1_CONNECTIONS = 4,
  parameter int unsigned MAX_INFLIGHT   = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [L1_CONNECTIONS-1:0]      req_valid,
  input  logic [L1_CONNECTIONS-1:0][31:0] req_addr,
  input  logic [L1_CONNECTIONS-1:0]      req_rnw,
  input  logic [L1_CONNECTIONS-1:0][31:0] req_wdata,
  output logic [L1_CONNECTIONS-1:0]      req_ready,
  output logic                           l2_valid,
  output logic [31:0]                    l2_addr,
  output logic                           l2_rnw,
  output logic [31:0]                    l2_wdata,
  output logic [1:0]                     l2_id,
  input  logic                           l2_ready,
  input  logic                           rsp_valid,
  input  logic [31:0]                    rsp_data,
  output logic [L1_CONNECTIONS-1:0]      port_rsp_valid,
  output logic [31:0]                    port_rsp_data
);

  localparam int unsigned ID_W  = 2;
  localparam int unsigned PTR_W = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
  localparam int unsigned CNT_W = $clog2(MAX_INFLIGHT) + 1;

  logic [ID_W-1:0]           start_idx;
  logic [ID_W-1:0]           gnt_idx;
  logic [ID_W-1:0]           cand;
  logic                      gnt_found;
  logic [L1_CONNECTIONS-1:0] eligible;
  logic                      can_issue;
  logic                      xfer;
  logic                      push;
  logic                      pop;
  logic                      fifo_full;
  logic                      fifo_empty;

  logic [ID_W-1:0]  fifo_q [MAX_INFLIGHT];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_q;

  // Full is taken from the registered count, so a pop in the same cycle
  // never frees a slot for a read being granted alongside it.
  assign fifo_full  = (count_q == CNT_W'(MAX_INFLIGHT));
  assign fifo_empty = (count_q == '0);

  // Reads need a free FIFO slot; writes are always eligible.
  assign eligible = req_valid & ~(req_rnw & {L1_CONNECTIONS{fifo_full}});

  // Output register can take a new request when empty or draining this cycle.
  assign can_issue = ~l2_valid | l2_ready;

`ifdef L1_ARB_FIXED_PRIORITY_EN
  assign start_idx = '0;
`else
  logic [ID_W-1:0] last_grant;

  assign start_idx = (last_grant == ID_W'(L1_CONNECTIONS - 1)) ? '0
                                                                : last_grant + ID_W'(1);

  // Pointer advances only when a request actually transfers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= ID_W'(L1_CONNECTIONS - 1);
    end else if (xfer) begin
      last_grant <= gnt_idx;
    end
  end
`endif

  // First eligible requestor at or after start_idx, wrapping.
  always_comb begin
    gnt_idx   = '0;
    gnt_found = 1'b0;
    cand      = '0;
    for (int unsigned k = 0; k < L1_CONNECTIONS; k++) begin
      cand = ID_W'((32'(start_idx) + k) % L1_CONNECTIONS);
      if (!gnt_found && eligible[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  // One-hot grant, suppressed while stalled or in reset.
  always_comb begin
    req_ready = '0;
    if (gnt_found && can_issue && !rst) begin
      req_ready = L1_CONNECTIONS'(1) << gnt_idx;
    end
  end

  assign xfer = |req_ready;
  assign push = xfer & req_rnw[gnt_idx];
  assign pop  = rsp_valid & ~fifo_empty;

  // L2 request register; holds steady while L2 back-pressures.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      l2_valid <= 1'b0;
      l2_addr  <= '0;
      l2_rnw   <= 1'b0;
      l2_wdata <= '0;
      l2_id    <= '0;
    end else if (xfer) begin
      l2_valid <= 1'b1;
      l2_addr  <= req_addr[gnt_idx];
      l2_rnw   <= req_rnw[gnt_idx];
      l2_wdata <= req_wdata[gnt_idx];
      l2_id    <= gnt_idx;
    end else if (l2_ready) begin
      l2_valid <= 1'b0;
    end
  end

  // ID FIFO storage; contents are meaningless outside the count window.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_ptr] <= gnt_idx;
    end
  end

  // ID FIFO pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == PTR_W'(MAX_INFLIGHT - 1)) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PTR_W'(MAX_INFLIGHT - 1)) ? '0 : rd_ptr + PTR_W'(1);
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Route the response to the requestor at the FIFO head.
  always_comb begin
    port_rsp_valid = '0;
    if (pop) begin
      port_rsp_valid = L1_CONNECTIONS'(1) << fifo_q[rd_ptr];
    end
  end

  assign port_rsp_data = rsp_data;

`ifndef SYNTHESIS
  // A response with nothing outstanding is an L2 protocol error.
  rsp_on_empty: assert property (@(posedge clk) disable iff (rst) rsp_valid |-> !fifo_empty)
    else $error("l1_round_robin_arbiter: rsp_valid with no outstanding read");
`endif

endmodule

// File: tb/tb_l1_round_robin_arbiter.sv
// Directed self-checking bench for l1_round_robin_arbiter. Expected L2
// requests and expected response destinations are queued when stimulus is
// driven and checked when the DUT transfers to L2 / receives a response.

module tb_l1_round_robin_arbiter;

  localparam int unsigned N = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req_valid;
  logic [N-1:0][31:0] req_addr;
  logic [N-1:0]      req_rnw;
  logic [N-1:0][31:0] req_wdata;
  logic [N-1:0]      req_ready;
  logic              l2_valid;
  logic [31:0]       l2_addr;
  logic              l2_rnw;
  logic [31:0]       l2_wdata;
  logic [1:0]        l2_id;
  logic              l2_ready;
  logic              rsp_valid;
  logic [31:0]       rsp_data;
  logic [N-1:0]      port_rsp_valid;
  logic [31:0]       port_rsp_data;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  logic [66:0]  sq[$];
  int unsigned  rq[$];

  l1_round_robin_arbiter #(.L1_CONNECTIONS(N), .MAX_INFLIGHT(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_addr       (req_addr),
    .req_rnw        (req_rnw),
    .req_wdata      (req_wdata),
    .req_ready      (req_ready),
    .l2_valid       (l2_valid),
    .l2_addr        (l2_addr),
    .l2_rnw         (l2_rnw),
    .l2_wdata       (l2_wdata),
    .l2_id          (l2_id),
    .l2_ready       (l2_ready),
    .rsp_valid      (rsp_valid),
    .rsp_data       (rsp_data),
    .port_rsp_valid (port_rsp_valid),
    .port_rsp_data  (port_rsp_data)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, check combinational outputs and any L2
  // transfer 1 time unit later, then queue what this cycle's grant implies.
  task automatic cycle(input logic [N-1:0] v, input logic [N-1:0] rnw, input logic l2r,
                       input logic rsp, input logic [31:0] rd,
                       input logic [N-1:0] exp_rdy, input string tag);
    logic [N-1:0] ep;
    @(negedge clk);
    req_valid = v;
    req_rnw   = rnw;
    l2_ready  = l2r;
    rsp_valid = rsp;
    rsp_data  = rd;
    #1;
    chk($sformatf("%s req_ready", tag), 80'(req_ready), 80'(exp_rdy));
    ep = '0;
    if (rsp && rq.size() > 0) ep = N'(1) << rq.pop_front();
    chk($sformatf("%s port_rsp_valid", tag), 80'(port_rsp_valid), 80'(ep));
    if (rsp) chk($sformatf("%s port_rsp_data", tag), 80'(port_rsp_data), 80'(rd));
    if (l2_valid && l2_ready) begin
      if (sq.size() == 0) begin
        n_vec++;
        n_err++;
        $error("FAIL %s l2 transfer: observed id %0d expected none", tag, l2_id);
      end else begin
        chk($sformatf("%s l2 request", tag), 80'({l2_id, l2_rnw, l2_addr, l2_wdata}),
            80'(sq.pop_front()));
      end
    end
    for (int i = 0; i < int'(N); i++) begin
      if (exp_rdy[i]) begin
        sq.push_back({2'(i), rnw[i], req_addr[i], req_wdata[i]});
        if (rnw[i]) rq.push_back(i);
      end
    end
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '1;
    req_rnw   = '1;
    l2_ready  = 1'b1;
    rsp_valid = 1'b0;
    rsp_data  = '0;
    for (int i = 0; i < int'(N); i++) begin
      req_addr[i]  = 32'h1000_0000 + 32'(i) * 32'h100;
      req_wdata[i] = 32'hCAFE_0000 + 32'(i);
    end

    // Reset state, with every requestor asking.
    repeat (2) @(negedge clk);
    #1;
    chk("rst l2_valid", 80'(l2_valid), 80'(0));
    chk("rst l2_addr", 80'(l2_addr), 80'(0));
    chk("rst l2_wdata", 80'(l2_wdata), 80'(0));
    chk("rst l2_id", 80'(l2_id), 80'(0));
    chk("rst l2_rnw", 80'(l2_rnw), 80'(0));
    chk("rst req_ready", 80'(req_ready), 80'(0));
    req_valid = '0;
    @(negedge clk);
    rst = 1'b0;

`ifdef L1_ARB_FIXED_PRIORITY_EN
    // IDs 0 and 3 always valid: ID 0 wins every cycle.
    for (int c = 0; c < 5; c++) cycle(4'b1001, 4'b0000, 1'b1, 1'b0, 32'h0, 4'b0001, "fixed");
    cycle(4'b0000, 4'b0000, 1'b1, 1'b0, 32'h0, 4'b0000, "fixed drain");
`else
    // All four reading, responses keep the FIFO from filling: 0,1,2,3,0.
    cycle(4'hF, 4'hF, 1'b1, 1'b0, 32'h0,  4'b0001, "rr c1");
    cycle(4'hF, 4'hF, 1'b1, 1'b1, 32'h10, 4'b0010, "rr c2");
    cycle(4'hF, 4'hF, 1'b1, 1'b1, 32'h11, 4'b0100, "rr c3");
    cycle(4'hF, 4'hF, 1'b1, 1'b1, 32'h12, 4'b1000, "rr c4");
    cycle(4'hF, 4'hF, 1'b1, 1'b1, 32'h13, 4'b0001, "rr c5");
    cycle(4'h0, 4'hF, 1'b1, 1'b1, 32'h14, 4'b0000, "rr drain");
    cycle(4'h0, 4'hF, 1'b1, 1'b0, 32'h0,  4'b0000, "rr idle");

    // Fill the FIFO; queued ID1 read stalls while ID2 write goes through.
    cycle(4'hF, 4'hF, 1'b1, 1'b0, 32'h0,  4'b0010, "full c1");
    cycle(4'hF, 4'hF, 1'b1, 1'b0, 32'h0,  4'b0100, "full c2");
    cycle(4'hF, 4'hF, 1'b1, 1'b0, 32'h0,  4'b1000, "full c3");
    cycle(4'hF, 4'hF, 1'b1, 1'b0, 32'h0,  4'b0001, "full c4");
    cycle(4'b0110, 4'b1011, 1'b1, 1'b0, 32'h0, 4'b0100, "full write");
    cycle(4'b0010, 4'b1011, 1'b1, 1'b1, 32'hD1, 4'b0000, "full pop");
    cycle(4'b0010, 4'b1011, 1'b1, 1'b0, 32'h0, 4'b0010, "full regrant");
    cycle(4'h0, 4'hF, 1'b1, 1'b1, 32'hD2, 4'b0000, "full drain1");
    cycle(4'h0, 4'hF, 1'b1, 1'b1, 32'hD3, 4'b0000, "full drain2");
    cycle(4'h0, 4'hF, 1'b1, 1'b1, 32'hD4, 4'b0000, "full drain3");
    cycle(4'h0, 4'hF, 1'b1, 1'b1, 32'hD5, 4'b0000, "full drain4");

    // L2 back-pressure for three cycles.
    req_addr[2] = 32'h8000_0040;
    cycle(4'b0100, 4'h0, 1'b1, 1'b0, 32'h0, 4'b0100, "stall grant");
    for (int c = 0; c < 3; c++) begin
      cycle(4'hF, 4'h0, 1'b0, 1'b0, 32'h0, 4'b0000, "stall hold");
      chk("stall l2_valid", 80'(l2_valid), 80'(1));
      chk("stall l2_addr", 80'(l2_addr), 80'(32'h8000_0040));
      chk("stall l2_id", 80'(l2_id), 80'(2));
      chk("stall l2_wdata", 80'(l2_wdata), 80'(32'hCAFE_0002));
    end
    cycle(4'hF, 4'h0, 1'b1, 1'b0, 32'h0, 4'b1000, "stall release");
    cycle(4'h0, 4'h0, 1'b1, 1'b0, 32'h0, 4'b0000, "stall drain");
    req_addr[2] = 32'h1000_0200;

    // Responses routed back in issue order 3,0,2.
    cycle(4'b1000, 4'hF, 1'b1, 1'b0, 32'h0, 4'b1000, "route r3");
    cycle(4'b0001, 4'hF, 1'b1, 1'b0, 32'h0, 4'b0001, "route r0");
    cycle(4'b0100, 4'hF, 1'b1, 1'b0, 32'h0, 4'b0100, "route r2");
    cycle(4'h0, 4'hF, 1'b1, 1'b1, 32'hA, 4'b0000, "route rspA");
    cycle(4'h0, 4'hF, 1'b1, 1'b1, 32'hB, 4'b0000, "route rspB");
    cycle(4'h0, 4'hF, 1'b1, 1'b1, 32'hC, 4'b0000, "route rspC");

    // Reset while a request is held and two reads are outstanding.
    cycle(4'hF, 4'hF, 1'b1, 1'b0, 32'h0, 4'b1000, "mrst c1");
    cycle(4'hF, 4'hF, 1'b1, 1'b0, 32'h0, 4'b0001, "mrst c2");
    cycle(4'h0, 4'hF, 1'b0, 1'b0, 32'h0, 4'b0000, "mrst c3");
    chk("mrst held l2_valid", 80'(l2_valid), 80'(1));
    req_valid = '1;
    l2_ready  = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    chk("mrst async l2_valid", 80'(l2_valid), 80'(0));
    chk("mrst req_ready", 80'(req_ready), 80'(0));
    sq.delete();
    rq.delete();
    @(negedge clk);
    req_valid = '0;
    rst = 1'b0;
    // Empty FIFO after reset: exactly four reads fit, starting at ID 0.
    cycle(4'hF, 4'hF, 1'b1, 1'b0, 32'h0, 4'b0001, "post c1");
    cycle(4'hF, 4'hF, 1'b1, 1'b0, 32'h0, 4'b0010, "post c2");
    cycle(4'hF, 4'hF, 1'b1, 1'b0, 32'h0, 4'b0100, "post c3");
    cycle(4'hF, 4'hF, 1'b1, 1'b0, 32'h0, 4'b1000, "post c4");
    cycle(4'hF, 4'hF, 1'b1, 1'b0, 32'h0, 4'b0000, "post full");
    cycle(4'h0, 4'hF, 1'b1, 1'b1, 32'hE0, 4'b0000, "post rsp0");
    cycle(4'h0, 4'hF, 1'b1, 1'b1, 32'hE1, 4'b0000, "post rsp1");
    cycle(4'h0, 4'hF, 1'b1, 1'b1, 32'hE2, 4'b0000, "post rsp2");
    cycle(4'h0, 4'hF, 1'b1, 1'b1, 32'hE3, 4'b0000, "post rsp3");
`endif

    chk("end pending l2", 80'(sq.size()), 80'(0));
    chk("end pending rsp", 80'(rq.size()), 80'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
